lfsr_galois_checker: RTL and testbench
======================================

# lfsr_galois_checker

Receive-side companion to the Galois LFSR generator: samples the generator's parallel state word each enabled cycle, synchronises a local Galois LFSR to it, and then flywheels that LFSR to flag and count mismatching words. Sits at the far end of a link or a BIST path fed by the LFSR generator with the same MAX_LEN, POLY_I and Galois convention. Reports lock status, a per-word error pulse and a saturating error count.

## Interface
- MAX_LEN, 8: LFSR width in bits.
- LOCK_CNT, 4: consecutive correct predictions required to declare lock (1..15).
- LOSS_CNT, 3: consecutive mismatches in lock that drop lock (1..15).
- CNT_W, 16: error counter width.
- CLK_I  in  1  clock, rising edge.
- RST_N_I  in  1  reset, asynchronous, active-low.
- EN_I  in  1  sample valid; DATA_I is taken only when high.
- LOAD_I  in  1  resynchronise request (pairs with the generator reseed); forces HUNT.
- CLR_I  in  1  synchronous clear of ERR_CNT_O.
- POLY_I  in  MAX_LEN  feedback polynomial; must equal the generator's, stable while locked.
- DATA_I  in  MAX_LEN  received LFSR state word.
- LOCKED_O  out  1  high in LOCK state.
- ERR_O  out  1  one-cycle pulse: mismatch detected in LOCK.
- ERR_CNT_O  out  CNT_W  saturating count of mismatches in LOCK.

## Operation
- Galois step (shared with generator): next = (s >> 1) ^ (s[0] ? POLY_I : 0).
- States: HUNT, VERIFY, LOCK. Registers: exp (MAX_LEN), match_cnt, miss_cnt (4 b each).
- HUNT: on EN_I with DATA_I != 0: exp <= step(DATA_I), match_cnt <= 0, -> VERIFY. DATA_I == 0 (lock-up state) ignored, stay HUNT.
- VERIFY, EN_I: DATA_I == exp -> exp <= step(exp), match_cnt++; when match_cnt reaches LOCK_CNT -> LOCK, miss_cnt <= 0. Mismatch -> reseed: exp <= step(DATA_I), match_cnt <= 0, stay VERIFY (HUNT if DATA_I == 0). No errors counted in VERIFY.
- LOCK, EN_I: exp <= step(exp) always (flywheel, never reseeded). Match -> miss_cnt <= 0. Mismatch -> ERR_O pulse, ERR_CNT_O++ (saturates at all-ones), miss_cnt++; reaching LOSS_CNT -> HUNT.
- EN_I low: all state, exp and counters hold; ERR_O low.
- LOAD_I high (any state): -> HUNT next cycle, current sample discarded, ERR_CNT_O untouched. LOAD_I has priority over EN_I.
- CLR_I: ERR_CNT_O <= 0; if a counted mismatch coincides, result is 1 (clear then count).

## Timing
- Reset: state HUNT, exp 0, match_cnt/miss_cnt 0, LOCKED_O 0, ERR_O 0, ERR_CNT_O 0.
- All outputs registered; one-cycle latency from the sampling edge.
- LOCKED_O rises the cycle after the LOCK_CNT-th consecutive match, i.e. earliest 1 + LOCK_CNT enabled samples after HUNT (5 with defaults).
- ERR_O and ERR_CNT_O update the cycle after the mismatching sample; LOCKED_O falls the cycle after the LOSS_CNT-th consecutive miss, and that miss still pulses ERR_O and counts.
- Reset asserted mid-operation: immediate return to reset values, no partial count.

## Structure
- Package lfsr_pkg: function galois_step(s, poly) with the convention above, used by both generator and checker; typedef enum chk_state_t {HUNT, VERIFY, LOCK}.
- No sub-module; single FSM plus counters, ~150-250 lines.

## Test plan
- Reset, POLY_I=8'b10011001, feed generator sequence from seed 8'hE7 (8'hE7, 8'hEA, 8'h75, ...) with EN_I=1 -> LOCKED_O rises after 5th sample, ERR_CNT_O stays 0 over 200 words.
- Locked, corrupt one word (flip bit 0) -> single ERR_O pulse, ERR_CNT_O=1, LOCKED_O stays 1, next word matches.
- Locked, corrupt 3 consecutive words -> ERR_CNT_O=3, LOCKED_O falls after 3rd, relock after 5 clean words.
- Feed 8'h00 repeatedly -> stays HUNT, LOCKED_O=0, ERR_CNT_O=0; EN_I toggled 50% on clean stream -> lock still after 5 enabled samples.
- Locked, pulse LOAD_I with generator reseeded to 8'h5A -> HUNT, relock, no errors counted.
- Force 2^CNT_W+5 errors (CNT_W=4 build) -> ERR_CNT_O saturates at 4'hF; CLR_I with coincident error -> 1.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the Galois LFSR generator/checker pair.
package lfsr_pkg;

    // Widest LFSR the shared step function handles; callers zero-extend and truncate.
    localparam int unsigned LFSR_MAX_W = 64;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } chk_state_t;

    // Galois step: shift right, fold the polynomial in when the outgoing bit is set.
    // Zero-extension of s and poly above the LFSR width keeps the truncated result exact.
    function automatic logic [LFSR_MAX_W-1:0] galois_step(
        input logic [LFSR_MAX_W-1:0] s,
        input logic [LFSR_MAX_W-1:0] poly
    );
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/lfsr_galois_checker.sv
// Receive-side Galois LFSR checker: synchronises a local LFSR to the incoming
// state words, then flywheels it to flag and count mismatching words.
module lfsr_galois_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 8,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               CLK_I,
    input  logic               RST_N_I,
    input  logic               EN_I,
    input  logic               LOAD_I,
    input  logic               CLR_I,
    input  logic [MAX_LEN-1:0] POLY_I,
    input  logic [MAX_LEN-1:0] DATA_I,
    output logic               LOCKED_O,
    output logic               ERR_O,
    output logic [CNT_W-1:0]   ERR_CNT_O
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    chk_state_t         r_state;
    logic [MAX_LEN-1:0] r_exp;
    logic [3:0]         r_match_cnt;
    logic [3:0]         r_miss_cnt;
    logic               r_locked;
    logic               r_err;
    logic [CNT_W-1:0]   r_err_cnt;

    logic [MAX_LEN-1:0] w_step_data;
    logic [MAX_LEN-1:0] w_step_exp;
    logic               w_hit;
    logic               w_data_zero;
    logic [3:0]         w_match_inc;
    logic [3:0]         w_miss_inc;
    logic               w_count_err;
    logic [CNT_W-1:0]   w_cnt_base;

    assign w_step_data = MAX_LEN'(galois_step(LFSR_MAX_W'(DATA_I), LFSR_MAX_W'(POLY_I)));
    assign w_step_exp  = MAX_LEN'(galois_step(LFSR_MAX_W'(r_exp),  LFSR_MAX_W'(POLY_I)));
    assign w_hit       = (DATA_I == r_exp);
    assign w_data_zero = (DATA_I == '0);
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_miss_inc  = r_miss_cnt + 4'd1;

    // Only mismatches seen while locked are errors; a resync request discards the sample.
    assign w_count_err = EN_I && !LOAD_I && (r_state == LOCK) && !w_hit;
    // Clear is applied first so a coincident error leaves the count at one.
    assign w_cnt_base  = CLR_I ? '0 : r_err_cnt;

    // HUNT/VERIFY/LOCK sequencing with registered lock and error-pulse outputs.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state     <= HUNT;
            r_exp       <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (LOAD_I) begin
                r_state     <= HUNT;
                r_locked    <= 1'b0;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
            end else if (EN_I) begin
                case (r_state)
                    HUNT: begin
                        if (!w_data_zero) begin
                            r_exp       <= w_step_data;
                            r_match_cnt <= '0;
                            r_state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (w_hit) begin
                            r_exp       <= w_step_exp;
                            r_match_cnt <= w_match_inc;
                            if (w_match_inc == LOCK_N) begin
                                r_state    <= LOCK;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= '0;
                            end
                        end else if (w_data_zero) begin
                            r_match_cnt <= '0;
                            r_state     <= HUNT;
                        end else begin
                            r_exp       <= w_step_data;
                            r_match_cnt <= '0;
                        end
                    end
                    LOCK: begin
                        r_exp <= w_step_exp;
                        if (w_hit) begin
                            r_miss_cnt <= '0;
                        end else begin
                            r_err      <= 1'b1;
                            r_miss_cnt <= w_miss_inc;
                            if (w_miss_inc == LOSS_N) begin
                                r_state  <= HUNT;
                                r_locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter with synchronous clear.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_err_cnt <= '0;
        end else if (w_count_err) begin
            r_err_cnt <= (w_cnt_base == '1) ? w_cnt_base : w_cnt_base + CNT_W'(1);
        end else begin
            r_err_cnt <= w_cnt_base;
        end
    end

    assign LOCKED_O  = r_locked;
    assign ERR_O     = r_err;
    assign ERR_CNT_O = r_err_cnt;

endmodule

// File: tb/tb_lfsr_galois_checker.sv
// Self-checking bench for lfsr_galois_checker with a history-based reference model.
module tb_lfsr_galois_checker;

    localparam int W      = 8;
    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;
    localparam int CW     = 4;
    localparam logic [W-1:0] POLY = 8'b10011001;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic          load  = 1'b0;
    logic          clr   = 1'b0;
    logic [W-1:0]  poly  = POLY;
    logic [W-1:0]  data  = '0;
    logic          locked;
    logic          err;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    lfsr_galois_checker #(
        .MAX_LEN (W),
        .LOCK_CNT(LOCK_N),
        .LOSS_CNT(LOSS_N),
        .CNT_W   (CW)
    ) dut (
        .CLK_I    (clk),
        .RST_N_I  (rst_n),
        .EN_I     (en),
        .LOAD_I   (load),
        .CLR_I    (clr),
        .POLY_I   (poly),
        .DATA_I   (data),
        .LOCKED_O (locked),
        .ERR_O    (err),
        .ERR_CNT_O(err_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: lock is judged from the run length of words that each
    // follow the previous one by the generator rule; once locked, a free-running
    // prediction is compared against every enabled word.
    bit           m_locked;
    int           m_run;
    int           m_miss;
    bit           m_err;
    int           m_cnt;
    logic [W-1:0] m_prev;
    logic [W-1:0] m_pred;
    logic [W-1:0] gen;

    function automatic logic [W-1:0] nxt(input logic [W-1:0] s);
        logic [W-1:0] r;
        r = s / 2;
        if (s % 2 == 1) r = r ^ POLY;
        return r;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_miss = 0; m_err = 0; m_cnt = 0;
        m_prev = '0; m_pred = '0;
    endtask

    task automatic model_update(input bit e, input bit l, input bit c, input logic [W-1:0] d);
        m_err = 0;
        if (c) m_cnt = 0;
        if (l) begin
            m_locked = 0; m_run = 0; m_miss = 0;
        end else if (e) begin
            if (m_locked) begin
                if (d == m_pred) begin
                    m_miss = 0;
                end else begin
                    m_err = 1;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                    m_miss++;
                    if (m_miss == LOSS_N) begin
                        m_locked = 0; m_run = 0;
                    end
                end
                m_pred = nxt(m_pred);
            end else begin
                if (d == 0) m_run = 0;
                else if (m_run > 0 && d == nxt(m_prev)) m_run++;
                else m_run = 1;
                m_prev = d;
                if (m_run == LOCK_N + 1) begin
                    m_locked = 1; m_miss = 0; m_pred = nxt(d);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("locked", 32'(locked), 32'(m_locked));
        check("err", 32'(err), 32'(m_err));
        check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    endtask

    task automatic cyc(input bit e, input bit l, input bit c, input logic [W-1:0] d);
        en = e; load = l; clr = c; data = d;
        @(posedge clk);
        model_update(e, l, c, d);
        #1;
        check_model();
    endtask

    // Present the next generator word (optionally corrupted) or an idle cycle.
    task automatic feed(input bit e, input logic [W-1:0] mask);
        if (e) begin
            cyc(1'b1, 1'b0, 1'b0, gen ^ mask);
            gen = nxt(gen);
        end else begin
            cyc(1'b0, 1'b0, 1'b0, W'($urandom));
        end
    endtask

    // Generator reseed paired with a resync request; the reseed word itself is discarded.
    task automatic reseed(input logic [W-1:0] seed);
        cyc(1'b0, 1'b1, 1'b0, seed);
        gen = nxt(seed);
    endtask

    function automatic logic [W-1:0] rand_bit();
        logic [W-1:0] one;
        one = 1;
        return one << $urandom_range(W - 1);
    endfunction

    initial begin
        int n_en;
        int cnt_before;
        int r;
        logic [W-1:0] s;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cnt", 32'(err_cnt), 0);
        rst_n = 1'b1;

        // Clean stream from seed E7: lock after the 5th sample, no errors.
        gen = 8'hE7;
        for (int i = 0; i < 200; i++) begin
            feed(1'b1, '0);
            if (i == 3) check("lock_early", 32'(locked), 0);
            if (i == 4) check("lock_at5", 32'(locked), 1);
        end
        check("clean_cnt", 32'(err_cnt), 0);

        // Single corrupted word.
        feed(1'b1, 8'h01);
        check("single_err", 32'(err), 1);
        check("single_cnt", 32'(err_cnt), 1);
        check("single_locked", 32'(locked), 1);
        feed(1'b1, '0);
        check("single_next", 32'(err), 0);

        // Clear, then three consecutive misses drop lock; five clean words relock.
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("clr_cnt", 32'(err_cnt), 0);
        for (int i = 0; i < 3; i++) feed(1'b1, rand_bit());
        check("loss_cnt", 32'(err_cnt), 3);
        check("loss_locked", 32'(locked), 0);
        check("loss_err", 32'(err), 1);
        for (int i = 0; i < 5; i++) feed(1'b1, '0);
        check("relock", 32'(locked), 1);

        // Asynchronous reset mid-operation.
        feed(1'b1, 8'h10);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_locked", 32'(locked), 0);
        check("arst_cnt", 32'(err_cnt), 0);
        check("arst_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero words never start synchronisation.
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        check("zero_locked", 32'(locked), 0);
        check("zero_cnt", 32'(err_cnt), 0);

        // Enable toggled randomly: lock after 5 enabled samples.
        gen = 8'h3C;
        n_en = 0;
        for (int i = 0; i < 60 && n_en < 5; i++) begin
            if ($urandom_range(1) == 1) begin
                feed(1'b1, '0);
                n_en++;
            end else begin
                feed(1'b0, '0);
            end
        end
        check("en_toggle_n", n_en, 5);
        check("en_toggle_lock", 32'(locked), 1);

        // Resync to reseeded generator: no errors counted.
        cnt_before = m_cnt;
        reseed(8'h5A);
        check("load_unlock", 32'(locked), 0);
        for (int i = 0; i < 5; i++) feed(1'b1, '0);
        check("load_relock", 32'(locked), 1);
        check("load_cnt", 32'(err_cnt), cnt_before);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(99);
            if (r < 3) begin
                s = W'($urandom_range(255, 1));
                reseed(s);
            end else if (r < 10) begin
                feed(1'b1, rand_bit());
            end else if (r < 30) begin
                feed(1'b0, '0);
            end else if (r < 33) begin
                cyc(1'b1, 1'b0, 1'b1, gen);
                gen = nxt(gen);
            end else begin
                feed(1'b1, '0);
            end
        end

        // Saturation of the error counter, then clear with a coincident error.
        cyc(1'b0, 1'b0, 1'b1, '0);
        reseed(8'hC3);
        for (int i = 0; i < 5; i++) feed(1'b1, '0);
        check("sat_lock", 32'(locked), 1);
        for (int k = 0; k < (1 << CW) + 5; k++) begin
            feed(1'b1, rand_bit());
            feed(1'b1, '0);
        end
        check("sat_cnt", 32'(err_cnt), 32'hF);
        check("sat_locked", 32'(locked), 1);
        cyc(1'b1, 1'b0, 1'b1, gen ^ 8'h80);
        gen = nxt(gen);
        check("clr_err_cnt", 32'(err_cnt), 1);
        check("clr_err_pulse", 32'(err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
